// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller: source indices,
// dispatch vectors, default register addresses and FSM states.
package int_pkg;

  localparam int NUM_SRC = 5;

  localparam logic [15:0] IF_ADDR_DEFAULT = 16'hFF0F;
  localparam logic [15:0] IE_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    SRC_VBLANK = 3'd0,
    SRC_LCDC   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } int_src_e;

  localparam logic [7:0] VEC_VBLANK = 8'h40;
  localparam logic [7:0] VEC_LCDC   = 8'h48;
  localparam logic [7:0] VEC_TIMER  = 8'h50;
  localparam logic [7:0] VEC_SERIAL = 8'h58;
  localparam logic [7:0] VEC_JOYPAD = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } int_state_e;

  function automatic logic [7:0] vec_of(input logic [2:0] k);
    logic [7:0] v;
    case (int_src_e'(k))
      SRC_VBLANK: v = VEC_VBLANK;
      SRC_LCDC:   v = VEC_LCDC;
      SRC_TIMER:  v = VEC_TIMER;
      SRC_SERIAL: v = VEC_SERIAL;
      SRC_JOYPAD: v = VEC_JOYPAD;
      default:    v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [4:0] src_onehot(input logic [2:0] k);
    return 5'b00001 << k;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU register bus of the interrupt controller (address, data, strobes).
interface interrupt_controller_if;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;

  modport master (output a, din, rd, wr, input dout);
  modport slave  (input a, din, rd, wr, output dout);
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module int_prio_enc
  import int_pkg::*;
(
  input  logic [4:0] pend,
  output logic       valid,
  output logic [2:0] idx
);

  // Lowest-index-wins selection over the pending/enabled sources.
  always_comb begin
    valid = 1'b1;
    idx   = SRC_VBLANK;
    casez (pend)
      5'b????1: idx = SRC_VBLANK;
      5'b???10: idx = SRC_LCDC;
      5'b??100: idx = SRC_TIMER;
      5'b?1000: idx = SRC_SERIAL;
      5'b10000: idx = SRC_JOYPAD;
      default: begin
        valid = 1'b0;
        idx   = SRC_VBLANK;
      end
    endcase
  end

endmodule

// File: rtl/interrupt_controller.sv
// Five-source interrupt controller with IF/IE registers and IDLE/REQ/ACK dispatch FSM.
// Optional ACK watchdog enabled by defining INT_ACK_TIMEOUT_EN.
module interrupt_controller
  import int_pkg::*;
#(
  parameter logic [15:0] IF_ADDR     = IF_ADDR_DEFAULT,
  parameter logic [15:0] IE_ADDR     = IE_ADDR_DEFAULT,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  interrupt_controller_if.slave bus,
  input  logic       int_vblank_req,
  input  logic       int_lcdc_req,
  input  logic       int_timer_req,
  input  logic       int_serial_req,
  input  logic       int_joypad_req,
  output logic       int_vblank_ack,
  output logic       int_lcdc_ack,
  output logic       int_timer_ack,
  output logic       int_serial_ack,
  output logic       int_joypad_ack,
  output logic       cpu_int_req,
  output logic [7:0] cpu_int_vec,
  input  logic       cpu_int_ack
);

  logic [4:0] req_s;
  logic [4:0] req_d_r;
  logic [4:0] edge_s;
  logic [4:0] if_r;
  logic [4:0] if_nxt_s;
  logic [7:0] ie_r;
  logic [7:0] ie_nxt_s;
  logic [4:0] pend_s;
  logic       valid_s;
  logic [2:0] k_s;
  logic [2:0] k_r;
  logic [2:0] k_nxt_s;
  logic [4:0] ack_r;
  logic [4:0] ack_nxt_s;
  logic       cpu_int_req_r;
  logic       wr_if_s;
  logic       wr_ie_s;
  logic       take_ack_s;
  logic       ack_expired_s;
  logic [7:0] dout_s;
  logic [7:0] vec_s;
  logic       unused_rd_s;

  int_state_e state_r;
  int_state_e state_nxt_s;

  assign req_s  = {int_joypad_req, int_serial_req, int_timer_req, int_lcdc_req, int_vblank_req};
  assign edge_s = req_s & ~req_d_r;
  assign pend_s = if_r & ie_r[4:0];

  assign wr_if_s    = bus.wr && (bus.a == IF_ADDR);
  assign wr_ie_s    = bus.wr && (bus.a == IE_ADDR);
  assign take_ack_s = (state_r == ST_REQ) && cpu_int_ack && valid_s;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_rd_s = bus.rd;

  int_prio_enc u_prio_enc (
    .pend  (pend_s),
    .valid (valid_s),
    .idx   (k_s)
  );

`ifdef INT_ACK_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] ack_cnt_r;

  assign ack_expired_s = (ack_cnt_r == CNT_W'(ACK_TIMEOUT - 1));

  // Cycles spent in ACK; restarts on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACK) && (state_nxt_s == ST_ACK)) begin
      ack_cnt_r <= ack_cnt_r + CNT_W'(1);
    end else begin
      ack_cnt_r <= {CNT_W{1'b0}};
    end
  end
`else
  logic [7:0] unused_timeout_s;

  assign unused_timeout_s = 8'(ACK_TIMEOUT);
  assign ack_expired_s    = 1'b0;
`endif

  // IF update: bus write first, then the serviced bit clears, then new edges win.
  always_comb begin
    if_nxt_s = if_r;
    if (wr_if_s) begin
      if_nxt_s = bus.din[4:0];
    end else begin
      if_nxt_s = if_r;
    end
    if (take_ack_s) begin
      if_nxt_s = if_nxt_s & ~src_onehot(k_s);
    end else begin
      if_nxt_s = if_nxt_s;
    end
    if_nxt_s = if_nxt_s | edge_s;
  end

  // IE register load.
  always_comb begin
    if (wr_ie_s) begin
      ie_nxt_s = bus.din;
    end else begin
      ie_nxt_s = ie_r;
    end
  end

  // Dispatch FSM next state, serviced-source latch and ack decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!valid_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cpu_int_ack) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_ACK: begin
        if (!req_s[k_r] || ack_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    if (take_ack_s) begin
      k_nxt_s = k_s;
    end else begin
      k_nxt_s = k_r;
    end

    if (state_nxt_s == ST_ACK) begin
      ack_nxt_s = src_onehot(k_nxt_s);
    end else begin
      ack_nxt_s = 5'b00000;
    end
  end

  // State, register file and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_d_r       <= 5'b00000;
      if_r          <= 5'b00000;
      ie_r          <= 8'h00;
      state_r       <= ST_IDLE;
      k_r           <= 3'd0;
      ack_r         <= 5'b00000;
      cpu_int_req_r <= 1'b0;
    end else begin
      req_d_r       <= req_s;
      if_r          <= if_nxt_s;
      ie_r          <= ie_nxt_s;
      state_r       <= state_nxt_s;
      k_r           <= k_nxt_s;
      ack_r         <= ack_nxt_s;
      cpu_int_req_r <= (state_nxt_s == ST_REQ);
    end
  end

  // Vector tracks the currently winning source while requesting.
  always_comb begin
    if ((state_r == ST_REQ) && valid_s) begin
      vec_s = vec_of(k_s);
    end else begin
      vec_s = 8'h00;
    end
  end

  // Register read mux.
  always_comb begin
    if (bus.a == IF_ADDR) begin
      dout_s = {3'b111, if_r};
    end else if (bus.a == IE_ADDR) begin
      dout_s = ie_r;
    end else begin
      dout_s = 8'hFF;
    end
  end

  assign bus.dout       = dout_s;
  assign cpu_int_req    = cpu_int_req_r;
  assign cpu_int_vec    = vec_s;
  assign int_vblank_ack = ack_r[0];
  assign int_lcdc_ack   = ack_r[1];
  assign int_timer_ack  = ack_r[2];
  assign int_serial_ack = ack_r[3];
  assign int_joypad_ack = ack_r[4];

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: fixed vector table, directed handshake sequences and
// randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam int ACK_TO = 15;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACK  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_controller_if bus_if();

  logic [4:0] req;
  logic       cpu_ack;
  logic       cpu_int_req;
  logic [7:0] cpu_int_vec;
  logic       ack_vb, ack_lc, ack_tm, ack_se, ack_jp;
  logic [4:0] acks;
  assign acks = {ack_jp, ack_se, ack_tm, ack_lc, ack_vb};

  interrupt_controller #(
    .IF_ADDR     (16'hFF0F),
    .IE_ADDR     (16'hFFFF),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .int_vblank_req (req[0]),
    .int_lcdc_req   (req[1]),
    .int_timer_req  (req[2]),
    .int_serial_req (req[3]),
    .int_joypad_req (req[4]),
    .int_vblank_ack (ack_vb),
    .int_lcdc_ack   (ack_lc),
    .int_timer_ack  (ack_tm),
    .int_serial_ack (ack_se),
    .int_joypad_ack (ack_jp),
    .cpu_int_req    (cpu_int_req),
    .cpu_int_vec    (cpu_int_vec),
    .cpu_int_ack    (cpu_ack)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [4:0] m_prev;
  int         m_phase;
  int         m_k;
  int         m_cyc;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  din;
    logic        wr;
    logic [4:0]  rq;
    logic        ak;
    logic [7:0]  e_dout;
    logic        e_req;
    logic [7:0]  e_vec;
    logic [4:0]  e_acks;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] got();
    return {10'b0, cpu_int_req, cpu_int_vec, acks, bus_if.dout};
  endfunction

  function automatic logic [31:0] model_expect();
    logic [4:0] p;
    int         k;
    logic [7:0] v, d;
    logic [4:0] ak;
    p  = m_if & m_ie[4:0];
    k  = lowest(p);
    v  = (m_phase == P_REQ && k >= 0) ? 8'(64 + 8 * k) : 8'h00;
    ak = (m_phase == P_ACK) ? 5'(1 << m_k) : 5'b00000;
    if (bus_if.a == 16'hFF0F) d = {3'b111, m_if};
    else if (bus_if.a == 16'hFFFF) d = m_ie;
    else d = 8'hFF;
    return {10'b0, (m_phase == P_REQ), v, ak, d};
  endfunction

  task automatic model_reset();
    m_if = 5'b0; m_ie = 8'h00; m_prev = 5'b0; m_phase = P_IDLE; m_k = 0; m_cyc = 0;
  endtask

  // One clock of the rules: write, then service clear, then new edges.
  task automatic model_step();
    logic [4:0] p, nif;
    int k, nph;
    p   = m_if & m_ie[4:0];
    k   = lowest(p);
    nif = m_if;
    if (bus_if.wr && bus_if.a == 16'hFF0F) nif = bus_if.din[4:0];
    if (m_phase == P_REQ && cpu_ack && k >= 0) nif[k] = 1'b0;
    nif = nif | (req & ~m_prev);
    nph = m_phase;
    case (m_phase)
      P_IDLE: if (p != 5'b0) nph = P_REQ;
      P_REQ: begin
        if (p == 5'b0) nph = P_IDLE;
        else if (cpu_ack) begin nph = P_ACK; m_k = k; m_cyc = 1; end
      end
      P_ACK: begin
        if (!req[m_k]) nph = P_IDLE;
`ifdef INT_ACK_TIMEOUT_EN
        else if (m_cyc >= ACK_TO) nph = P_IDLE;
        else m_cyc++;
`endif
      end
      default: nph = P_IDLE;
    endcase
    if (bus_if.wr && bus_if.a == 16'hFFFF) m_ie = bus_if.din;
    m_if = nif; m_prev = req; m_phase = nph;
  endtask

  task automatic set_in(input logic [15:0] a, input logic [7:0] din, input logic wr,
                        input logic [4:0] rq, input logic ak);
    bus_if.a = a; bus_if.din = din; bus_if.wr = wr; req = rq; cpu_ack = ak;
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, got(), model_expect());
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    bus_if.rd = 1'b0;
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_if", got(), {10'b0, 1'b0, 8'h00, 5'b0, 8'hE0});
    bus_if.a = 16'hFFFF;
    #1;
    check("reset_ie", got(), {10'b0, 1'b0, 8'h00, 5'b0, 8'h00});
    rst = 1'b1;

    //             a         din    wr    req       ack   dout   creq  vec    acks
    tbl[0]  = '{16'hFFFF, 8'h08, 1'b1, 5'b00000, 1'b0, 8'h08, 1'b0, 8'h00, 5'b00000};
    tbl[1]  = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE0, 1'b0, 8'h00, 5'b00000};
    tbl[2]  = '{16'hFF0F, 8'h00, 1'b0, 5'b01000, 1'b0, 8'hE8, 1'b0, 8'h00, 5'b00000};
    tbl[3]  = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE8, 1'b1, 8'h58, 5'b00000};
    tbl[4]  = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE8, 1'b1, 8'h58, 5'b00000};
    tbl[5]  = '{16'hFFFF, 8'h1F, 1'b1, 5'b00000, 1'b0, 8'h1F, 1'b1, 8'h58, 5'b00000};
    tbl[6]  = '{16'hFF0F, 8'h00, 1'b1, 5'b00000, 1'b0, 8'hE0, 1'b1, 8'h00, 5'b00000};
    tbl[7]  = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE0, 1'b0, 8'h00, 5'b00000};
    tbl[8]  = '{16'h1234, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hFF, 1'b0, 8'h00, 5'b00000};
    tbl[9]  = '{16'hFF0F, 8'h00, 1'b1, 5'b00100, 1'b0, 8'hE4, 1'b0, 8'h00, 5'b00000};
    tbl[10] = '{16'hFF0F, 8'h00, 1'b0, 5'b00100, 1'b0, 8'hE4, 1'b1, 8'h50, 5'b00000};
    tbl[11] = '{16'hFF0F, 8'h00, 1'b0, 5'b00100, 1'b1, 8'hE0, 1'b0, 8'h00, 5'b00100};
    tbl[12] = '{16'hFF0F, 8'h00, 1'b0, 5'b00100, 1'b0, 8'hE0, 1'b0, 8'h00, 5'b00100};
    tbl[13] = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE0, 1'b0, 8'h00, 5'b00000};
    tbl[14] = '{16'hFF0F, 8'h00, 1'b0, 5'b00000, 1'b0, 8'hE0, 1'b0, 8'h00, 5'b00000};

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].a, tbl[i].din, tbl[i].wr, tbl[i].rq, tbl[i].ak);
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("table_%0d", i), got(),
            {10'b0, tbl[i].e_req, tbl[i].e_vec, tbl[i].e_acks, tbl[i].e_dout});
    end

    // All flags pending: vblank serviced first, ack held until its req drops
    set_in(16'hFFFF, 8'h1F, 1'b1, 5'b00001, 1'b0); tick("all_ie");
    set_in(16'hFF0F, 8'h1F, 1'b1, 5'b00001, 1'b0); tick("all_if");
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b00001, 1'b0); tick("all_req");
    check("all_vec40", {24'b0, cpu_int_vec}, 32'h40);
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b00001, 1'b1); tick("all_ack");
    check("all_if_fe", {24'b0, bus_if.dout}, 32'hFE);
    check("all_vb_ack", {27'b0, acks}, 32'h01);
    cpu_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("all_hold");
      check("all_vb_held", {31'b0, ack_vb}, 32'h1);
    end
    req = 5'b00000; tick("all_drop");
    check("all_vb_released", {27'b0, acks}, 32'h00);
    tick("all_next");
    check("all_vec48", {24'b0, cpu_int_vec}, 32'h48);
    set_in(16'hFF0F, 8'h00, 1'b1, 5'b00000, 1'b0); tick("all_clear");
    bus_if.wr = 1'b0; tick("all_idle");

    // Serial held through ACK: no re-flag, ack and request fall together
    set_in(16'hFFFF, 8'h08, 1'b1, 5'b00000, 1'b0); tick("ser_ie");
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b01000, 1'b0); tick("ser_rise");
    tick("ser_req");
    check("ser_vec58", {24'b0, cpu_int_vec}, 32'h58);
    cpu_ack = 1'b1; tick("ser_ack");
    cpu_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("ser_hold");
      check("ser_no_reflag", {23'b0, ack_se, bus_if.dout}, {23'b0, 1'b1, 8'hE0});
    end
    req = 5'b00000; tick("ser_drop");
    check("ser_release", {22'b0, cpu_int_req, acks, bus_if.dout}, {22'b0, 1'b0, 5'b0, 8'hE0});
    tick("ser_after");

    // Reset asserted mid-ACK drops everything at once
    req = 5'b01000; tick("rst_rise");
    tick("rst_req");
    cpu_ack = 1'b1; tick("rst_ack");
    cpu_ack = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_mid_ack", got(), {10'b0, 1'b0, 8'h00, 5'b0, 8'hE0});
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 5'b00000;
    tick("rst_after");

`ifdef INT_ACK_TIMEOUT_EN
    set_in(16'hFFFF, 8'h01, 1'b1, 5'b00000, 1'b0); tick("to_ie");
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b00001, 1'b0); tick("to_rise");
    tick("to_req");
    cpu_ack = 1'b1; tick("to_ack");
    cpu_ack = 1'b0;
    cnt = (ack_vb == 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick("to_hold");
      if (ack_vb == 1'b1) cnt++;
      else break;
    end
    check("ack_timeout_len", 32'(cnt), 32'(ACK_TO));
`else
    set_in(16'hFFFF, 8'h01, 1'b1, 5'b00000, 1'b0); tick("wait_ie");
    set_in(16'hFF0F, 8'h00, 1'b0, 5'b00001, 1'b0); tick("wait_rise");
    tick("wait_req");
    cpu_ack = 1'b1; tick("wait_ack");
    cpu_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * ACK_TO; i++) begin
      tick("wait_hold");
      if (ack_vb == 1'b1) cnt++;
    end
    check("ack_no_timeout", 32'(cnt), 32'(2 * ACK_TO));
`endif
    req = 5'b00000; tick("cfg_drop");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0: bus_if.a = 16'hFF0F;
        1: bus_if.a = 16'hFFFF;
        default: bus_if.a = {4'hC, 12'($urandom)};
      endcase
      bus_if.din = 8'($urandom);
      bus_if.wr  = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      cpu_ack = ($urandom_range(0, 3) == 0);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter IF_ADDR, default 16'hFF0F, address of the interrupt flag register (IF).
REQ-002 SHALL have parameter IE_ADDR, default 16'hFFFF, address of the interrupt enable register (IE).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, maximum cycles spent in ACK (used only when the REQ-028 macro is defined).
REQ-004 SHALL have port clk  in  1  the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port a  in  16  CPU bus address.
REQ-007 SHALL have port din  in  8  CPU write data.
REQ-008 SHALL have port dout  out  8  CPU read data, combinational.
REQ-009 SHALL have ports rd and wr  in  1 each  CPU read and write strobes; a write is taken on any clock edge with wr high.
REQ-010 SHALL have ports int_vblank_req, int_lcdc_req, int_timer_req, int_serial_req and int_joypad_req  in  1 each  source request levels.
REQ-011 SHALL have ports int_vblank_ack, int_lcdc_ack, int_timer_ack, int_serial_ack and int_joypad_ack  out  1 each  source acknowledge levels.
REQ-012 SHALL have port cpu_int_req  out  1  interrupt request to the CPU.
REQ-013 SHALL have port cpu_int_vec  out  8  dispatch vector.
REQ-014 SHALL have port cpu_int_ack  in  1  single-cycle pulse from the CPU when it starts dispatch.

Function
REQ-015 SHALL hold IF[4:0] (bit0 vblank .. bit4 joypad) and IE[7:0] as registers.
REQ-016 SHALL set IF[k] one cycle after a rising edge of source k req; a level held high SHALL NOT set the bit again.
REQ-017 SHALL, on a write to IF_ADDR, load IF[4:0] from din[4:0]; on a write to IE_ADDR, load IE from din.
REQ-018 SHALL drive dout = {3'b111, IF} at IF_ADDR, IE at IE_ADDR, and 8'hFF at any other address.
REQ-019 SHALL implement the FSM IDLE -> REQ -> ACK -> IDLE.
REQ-020 SHALL go IDLE->REQ when (IF & IE[4:0]) != 0, and go REQ->IDLE if that term becomes 0 before cpu_int_ack.
REQ-021 SHALL assert cpu_int_req only in REQ.
REQ-022 SHALL drive cpu_int_vec = 8'h40 + 8*k, where k is the lowest pending and enabled bit, updated every cycle in REQ; vec = 8'h00 in IDLE and ACK.
REQ-023 SHALL, when cpu_int_ack is high in REQ, clear IF[k] for the k shown that cycle, latch k, and enter ACK; cpu_int_ack outside REQ SHALL be ignored.
REQ-024 SHALL, in ACK, hold int_<k>_ack high and all other acks low; ACK->IDLE once source k req is low.
REQ-025 SHALL apply same-cycle IF updates in this order: bus write, then ack clear, then edge set (a new edge always wins).
REQ-026 SHALL keep the source edge-detect registers running in all states.

Reset
REQ-027 SHALL, while rst is low, force IF=0, IE=0, FSM=IDLE, edge-detect registers=0, cpu_int_req=0, cpu_int_vec=8'h00, all acks=0; a reset mid-ACK SHALL drop the ack immediately, with no handshake completion.

Configuration
REQ-028 SHALL, when INT_ACK_TIMEOUT_EN is defined, count cycles in ACK and force ACK->IDLE after ACK_TIMEOUT cycles even if req stays high; without the macro, ACK SHALL wait indefinitely and no counter SHALL exist.

Structure
REQ-029 SHALL place the source index enum, vector constants (8'h40..8'h60) and default addresses in package int_pkg.
REQ-030 SHALL implement lowest-index-wins selection as sub-module int_prio_enc (5-bit in, valid plus 3-bit index out, combinational).

Verification
REQ-031 SHALL cover: IE=8'h08, pulse serial req -> IF reads 8'hE8, cpu_int_req=1, vec=8'h58.
REQ-032 SHALL cover: IF=8'h1F, IE=8'h1F, cpu_int_ack -> vec 8'h40 serviced, IF reads 8'hFE, int_vblank_ack high until vblank req drops.
REQ-033 SHALL cover: serial req held high through ACK, then dropped -> ack falls the same cycle FSM returns IDLE, no re-set of IF[3].
REQ-034 SHALL cover: same cycle, IF write 8'h00 and rising edge on timer -> IF reads 8'hE4.
REQ-035 SHALL cover: in REQ, software writes IF=8'h00 -> cpu_int_req drops next cycle, FSM returns IDLE, no ack driven.
REQ-036 SHALL cover: INT_ACK_TIMEOUT_EN defined, req stuck high -> ACK exits after exactly 15 cycles; rst low mid-ACK -> all outputs at reset values.
